prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning the instruction word width.
REQ-002 The block SHALL expose parameter PC_BITS, default 5, meaning the instruction memory address width, with DEPTH = 2^PC_BITS words.
REQ-003 The block SHALL expose parameter HOLD_CYCLES, default 2, meaning the number of cycles cpu_rst stays high after the final write (legal range 1..15).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  the input word is valid.
REQ-008 in_data  input  XLEN  instruction word.
REQ-009 in_last  input  1  this word is the final program word.
REQ-010 in_ready  output  1  the loader accepts a word this cycle.
REQ-011 reload  input  1  single-cycle request to restart loading; honoured only in RUN.
REQ-012 imem_we  output  1  instruction memory write strobe.
REQ-013 imem_addr  output  PC_BITS  instruction memory write address.
REQ-014 imem_wdata  output  XLEN  instruction memory write data.
REQ-015 cpu_rst  output  1  active-high reset held on the CPU core.
REQ-016 done  output  1  the program is loaded and the CPU is running.
REQ-017 err_overflow  output  1  the program exceeded DEPTH words (sticky).
REQ-018 word_count  output  PC_BITS+1  number of words written in the current load.

Function
REQ-019 The FSM SHALL have the states LOAD, HOLD, RUN and ERR.
REQ-020 A word SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-021 in_ready SHALL equal 1 only in LOAD, and SHALL be a registered output, not a combinational function of in_valid.
REQ-022 Each accepted word SHALL produce imem_we=1 on the following cycle, with imem_addr set to the word_count value at acceptance and imem_wdata set to the accepted in_data (one-cycle latency).
REQ-023 imem_we SHALL be 0 on every other cycle, and there SHALL be no write while in_valid is low.
REQ-024 word_count SHALL increment by 1 per accepted word, saturate at DEPTH, and hold its value through HOLD and RUN.
REQ-025 LOAD→HOLD: when an accepted word has in_last=1, in_ready SHALL drop on the next cycle.
REQ-026 LOAD→ERR: when the word written to address DEPTH-1 has in_last=0, the block SHALL go to ERR; the last-address write itself SHALL still occur.
REQ-027 If in_last=1 on address DEPTH-1, the block SHALL go to HOLD and SHALL NOT raise an error.
REQ-028 HOLD SHALL last HOLD_CYCLES cycles, counted from the cycle after the final imem_we pulse; cpu_rst SHALL stay 1 throughout HOLD.
REQ-029 HOLD→RUN: cpu_rst SHALL go to 0 and done SHALL go to 1 on the same edge.
REQ-030 RUN→LOAD: on reload=1, cpu_rst SHALL be 1, done 0 and word_count 0 on the next cycle, and in_ready SHALL be 1 on the next cycle.
REQ-031 reload SHALL be ignored in LOAD, HOLD and ERR.
REQ-032 ERR SHALL hold err_overflow=1, cpu_rst=1, in_ready=0, done=0 and imem_we=0 until rst is asserted; reload SHALL NOT clear ERR.
REQ-033 cpu_rst SHALL be 1 in every state except RUN.
REQ-034 cpu_rst SHALL be driven from a flop, with no combinational path from any input.

Reset
REQ-035 While rst=0, and immediately on its assertion independent of clk, the block SHALL force: state LOAD, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, done 0, err_overflow 0, word_count 0, hold counter 0.
REQ-036 in_ready SHALL first go to 1 on the first rising clk edge after rst deasserts.
REQ-037 Reset asserted mid-load SHALL discard any pending write (imem_we=0 immediately), and the next load SHALL restart at address 0.
REQ-038 Reset asserted in RUN SHALL drive cpu_rst=1 asynchronously.

Verification
REQ-039 Basic load: stream 3 words 0x11,0x22,0x33 back-to-back, with in_last on 0x33 -> writes to addr 0,1,2 one cycle after each accept; word_count=3; cpu_rst falls exactly HOLD_CYCLES=2 cycles after the last imem_we; done=1.
REQ-040 Bubbles: in_valid toggled 1,0,0,1,1 with in_last on the 3rd word -> exactly 3 imem_we pulses at addr 0,1,2; no write on idle cycles.
REQ-041 Overflow: 32 words with PC_BITS=5 and in_last never set -> 32 writes (addr 0..31), then err_overflow=1, in_ready=0 and cpu_rst=1 persist for 100 cycles; a reload pulse has no effect.
REQ-042 Exact fill: 32 words with in_last on word 32 -> no error, done=1, word_count=32.
REQ-043 Reload: in RUN, pulse reload, then load 2 words -> cpu_rst=1 on the next cycle; the new writes go to addr 0,1; word_count=2; done re-asserts after HOLD.
REQ-044 Mid-load reset: assert rst after 2 of 4 words -> imem_we, in_ready and done go to 0 and cpu_rst goes to 1 without a clock edge; after release, the first write goes to addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, holds the CPU in
// reset for HOLD_CYCLES cycles after the final write, then releases it.
// An image longer than DEPTH words parks the block in ERR until rst.
// HOLD_CYCLES must lie in 1..15 so it fits the 4-bit hold counter.
module prog_loader #(
    parameter int XLEN        = 32,
    parameter int PC_BITS     = 5,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [XLEN-1:0]    in_data,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               reload,
    output logic               imem_we,
    output logic [PC_BITS-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               cpu_rst,
    output logic               done,
    output logic               err_overflow,
    output logic [PC_BITS:0]   word_count
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // word_count value once the memory is full, and the index of the top word
    localparam logic [PC_BITS:0] FULL   = {1'b1, {PC_BITS{1'b0}}};
    localparam logic [PC_BITS:0] LAST_A = {1'b0, {PC_BITS{1'b1}}};
    localparam logic [3:0]       HOLD_N = 4'(HOLD_CYCLES);

    logic [1:0] state;
    logic [3:0] hold_cnt;
    logic       accept;

    // in_ready is registered and only ever high in LOAD, so this is the handshake
    assign accept = in_valid && in_ready && (state == S_LOAD);

    // Control FSM: state, handshake, CPU reset and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_LOAD;
            in_ready     <= 1'b0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            hold_cnt     <= 4'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept && in_last) begin
                        // last word wins over overflow, even at the top address
                        state    <= S_HOLD;
                        in_ready <= 1'b0;
                        hold_cnt <= 4'd0;
                    end else if (accept && (word_count == LAST_A)) begin
                        state        <= S_ERR;
                        in_ready     <= 1'b0;
                        err_overflow <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // first HOLD cycle carries the final write; count starts after it
                    if (hold_cnt == HOLD_N) begin
                        state    <= S_RUN;
                        cpu_rst  <= 1'b0;
                        done     <= 1'b1;
                        hold_cnt <= 4'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        state    <= S_LOAD;
                        cpu_rst  <= 1'b1;
                        done     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                S_ERR: begin
                    // sticky until rst; reload deliberately has no effect here
                    in_ready     <= 1'b0;
                    cpu_rst      <= 1'b1;
                    done         <= 1'b0;
                    err_overflow <= 1'b1;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    // Write port: one-cycle registered copy of each accepted word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                imem_addr  <= word_count[PC_BITS-1:0];
                imem_wdata <= in_data;
            end
        end
    end

    // Word counter: saturating, cleared only by rst or a reload from RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count <= '0;
        end else if ((state == S_RUN) && reload) begin
            word_count <= '0;
        end else if (accept && (word_count != FULL)) begin
            word_count <= word_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a per-cycle vector table for the basic,
// bubble and reload flows, then hand sequences for fill, overflow and reset.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err_overflow;
    logic [5:0]  word_count;

    int checks = 0;
    int errors = 0;

    prog_loader #(.XLEN(32), .PC_BITS(5), .HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .reload(reload),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err_overflow(err_overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        last;
        logic        rl;
        logic        rdy;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        crst;
        logic        dn;
        logic [5:0]  wc;
    } vec_t;

    vec_t tv [0:22];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic last,
                                input logic rl, input logic rdy, input logic we,
                                input logic [4:0] addr, input logic [31:0] wd,
                                input logic crst, input logic dn, input logic [5:0] wc);
        vec_t r;
        r.v = v; r.d = d; r.last = last; r.rl = rl; r.rdy = rdy; r.we = we;
        r.addr = addr; r.wd = wd; r.crst = crst; r.dn = dn; r.wc = wc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        v  data    last rl  | rdy we addr wd      crst dn wc
        tv[0]  = mk(0, 32'h0,  0, 0,    1, 0, 0, 32'h0,  1, 0, 0);
        tv[1]  = mk(1, 32'h11, 0, 0,    1, 1, 0, 32'h11, 1, 0, 1);
        tv[2]  = mk(1, 32'h22, 0, 0,    1, 1, 1, 32'h22, 1, 0, 2);
        tv[3]  = mk(1, 32'h33, 1, 0,    0, 1, 2, 32'h33, 1, 0, 3);
        tv[4]  = mk(0, 32'h0,  0, 0,    0, 0, 0, 32'h0,  1, 0, 3);
        tv[5]  = mk(0, 32'h0,  0, 0,    0, 0, 0, 32'h0,  1, 0, 3);
        tv[6]  = mk(0, 32'h0,  0, 0,    0, 0, 0, 32'h0,  0, 1, 3);
        tv[7]  = mk(0, 32'h0,  0, 0,    0, 0, 0, 32'h0,  0, 1, 3);
        tv[8]  = mk(0, 32'h0,  0, 1,    1, 0, 0, 32'h0,  1, 0, 0);
        tv[9]  = mk(1, 32'hA1, 0, 0,    1, 1, 0, 32'hA1, 1, 0, 1);
        tv[10] = mk(0, 32'h0,  0, 1,    1, 0, 0, 32'h0,  1, 0, 1);
        tv[11] = mk(0, 32'h0,  0, 0,    1, 0, 0, 32'h0,  1, 0, 1);
        tv[12] = mk(1, 32'hA2, 0, 0,    1, 1, 1, 32'hA2, 1, 0, 2);
        tv[13] = mk(1, 32'hA3, 1, 0,    0, 1, 2, 32'hA3, 1, 0, 3);
        tv[14] = mk(0, 32'h0,  0, 1,    0, 0, 0, 32'h0,  1, 0, 3);
        tv[15] = mk(1, 32'hFF, 0, 0,    0, 0, 0, 32'h0,  1, 0, 3);
        tv[16] = mk(0, 32'h0,  0, 0,    0, 0, 0, 32'h0,  0, 1, 3);
        tv[17] = mk(0, 32'h0,  0, 1,    1, 0, 0, 32'h0,  1, 0, 0);
        tv[18] = mk(1, 32'hB1, 0, 0,    1, 1, 0, 32'hB1, 1, 0, 1);
        tv[19] = mk(1, 32'hB2, 1, 0,    0, 1, 1, 32'hB2, 1, 0, 2);
        tv[20] = mk(0, 32'h0,  0, 0,    0, 0, 0, 32'h0,  1, 0, 2);
        tv[21] = mk(0, 32'h0,  0, 0,    0, 0, 0, 32'h0,  1, 0, 2);
        tv[22] = mk(0, 32'h0,  0, 0,    0, 0, 0, 32'h0,  0, 1, 2);

        // reset state
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_wc", word_count, 0);
        step();
        rst = 1'b1;
        #1;
        chk("ready_before_edge", in_ready, 0);

        // table: basic load, bubbles, ignored reload, reload with 2 words
        for (int i = 0; i <= 22; i++) begin
            in_valid = tv[i].v; in_data = tv[i].d; in_last = tv[i].last; reload = tv[i].rl;
            step();
            chk($sformatf("v%0d_ready", i), in_ready, tv[i].rdy);
            chk($sformatf("v%0d_we", i), imem_we, tv[i].we);
            if (tv[i].we) begin
                chk($sformatf("v%0d_addr", i), imem_addr, tv[i].addr);
                chk($sformatf("v%0d_wdata", i), imem_wdata, tv[i].wd);
            end
            chk($sformatf("v%0d_cpu_rst", i), cpu_rst, tv[i].crst);
            chk($sformatf("v%0d_done", i), done, tv[i].dn);
            chk($sformatf("v%0d_wc", i), word_count, tv[i].wc);
            chk($sformatf("v%0d_err", i), err_overflow, 0);
        end
        in_valid = 0; in_last = 0; reload = 0;

        // exact fill: 32 words, last on the top address
        reload = 1; step(); reload = 0;
        chk("fill_ready", in_ready, 1);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1; in_data = 32'h100 + i; in_last = (i == 31);
            step();
            chk($sformatf("fill_we%0d", i), imem_we, 1);
            chk($sformatf("fill_addr%0d", i), imem_addr, i);
            chk($sformatf("fill_wdata%0d", i), imem_wdata, 32'h100 + i);
        end
        in_valid = 0; in_last = 0;
        chk("fill_err", err_overflow, 0);
        chk("fill_ready_low", in_ready, 0);
        step(); step();
        chk("fill_cpu_rst_hold", cpu_rst, 1);
        step();
        chk("fill_done", done, 1);
        chk("fill_cpu_rst", cpu_rst, 0);
        chk("fill_wc", word_count, 32);
        chk("fill_err2", err_overflow, 0);

        // overflow: 32 words, no last
        reload = 1; step(); reload = 0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1; in_data = 32'h200 + i; in_last = 0;
            step();
            chk($sformatf("ovf_we%0d", i), imem_we, 1);
            chk($sformatf("ovf_addr%0d", i), imem_addr, i);
        end
        chk("ovf_wc", word_count, 32);
        for (int c = 0; c < 100; c++) begin
            reload = (c == 50);
            step();
            chk($sformatf("ovf_hold%0d", c),
                {err_overflow, in_ready, cpu_rst, imem_we, done}, 5'b10100);
        end
        reload = 0; in_valid = 0;

        // async reset out of ERR
        #2 rst = 0;
        #1;
        chk("err_rst_err", err_overflow, 0);
        chk("err_rst_wc", word_count, 0);
        #1 rst = 1;

        // reach RUN with a single word, then reset asynchronously
        step();
        in_valid = 1; in_data = 32'h55; in_last = 1;
        step();
        in_valid = 0; in_last = 0;
        chk("one_addr", imem_addr, 0);
        step(); step(); step();
        chk("one_run", cpu_rst, 0);
        #2 rst = 0;
        #1;
        chk("run_rst_cpu_rst", cpu_rst, 1);
        chk("run_rst_done", done, 0);
        #1 rst = 1;

        // mid-load reset after 2 of 4 words
        step();
        in_valid = 1; in_data = 32'hC0; step();
        in_data = 32'hC1; step();
        in_valid = 0;
        chk("mid_we_before", imem_we, 1);
        chk("mid_addr_before", imem_addr, 1);
        #2 rst = 0;
        #1;
        chk("mid_we", imem_we, 0);
        chk("mid_ready", in_ready, 0);
        chk("mid_done", done, 0);
        chk("mid_cpu_rst", cpu_rst, 1);
        chk("mid_wc", word_count, 0);
        #1 rst = 1;
        step();
        chk("mid_ready_after", in_ready, 1);
        in_valid = 1; in_data = 32'hD0; step();
        in_valid = 0;
        chk("mid_restart_we", imem_we, 1);
        chk("mid_restart_addr", imem_addr, 0);
        chk("mid_restart_wdata", imem_wdata, 32'hD0);
        step();
        chk("mid_idle_we", imem_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
